// File: rtl/instruction_fetch.sv
// Variable-length instruction fetch: byte-serial reads at the PC, assembles opcode + optional
// 16-bit operand, and hands it to decode over valid/ready. Define FETCH_STALL_CNT_EN for stall_count.
module instruction_fetch #(
    parameter int LONG_BIT = 7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] pc_count,
    output logic        pc_increment,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ready,
    input  logic        flush,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [7:0]  instr_opcode,
    output logic [15:0] instr_operand,
    output logic [15:0] instr_pc
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [15:0] stall_count
`endif
);

    typedef enum logic [1:0] {F_OP, F_LO, F_HI, HOLD} state_t;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [15:0] operand;
        logic [15:0] pc;
    } instr_t;

    // Partially assembled long instruction; published to the outputs only when complete.
    typedef struct packed {
        logic [7:0]  opcode;
        logic [7:0]  lo;
        logic [15:0] pc;
    } pend_t;

    state_t state;
    instr_t held;
    pend_t  pend;

    assign mem_addr      = pc_count;
    assign mem_rd        = reset & ~flush & (state != HOLD);
    assign pc_increment  = mem_rd & mem_ready;
    assign instr_opcode  = held.opcode;
    assign instr_operand = held.operand;
    assign instr_pc      = held.pc;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= F_OP;
            instr_valid <= 1'b0;
            held        <= '0;
            pend        <= '0;
        end else if (flush) begin
            state       <= F_OP;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                F_OP: if (mem_ready) begin
                    if (mem_rdata[LONG_BIT]) begin
                        pend.opcode <= mem_rdata;
                        pend.pc     <= pc_count;
                        pend.lo     <= 8'h00;
                        state       <= F_LO;
                    end else begin
                        held.opcode  <= mem_rdata;
                        held.operand <= 16'h0000;
                        held.pc      <= pc_count;
                        instr_valid  <= 1'b1;
                        state        <= HOLD;
                    end
                end
                F_LO: if (mem_ready) begin
                    pend.lo <= mem_rdata;
                    state   <= F_HI;
                end
                F_HI: if (mem_ready) begin
                    held.opcode  <= pend.opcode;
                    held.operand <= {mem_rdata, pend.lo};
                    held.pc      <= pend.pc;
                    instr_valid  <= 1'b1;
                    state        <= HOLD;
                end
                HOLD: if (instr_ready) begin
                    instr_valid <= 1'b0;
                    state       <= F_OP;
                end
                default: state <= F_OP;
            endcase
        end
    end

`ifdef FETCH_STALL_CNT_EN
    // Saturating count of wait-state cycles; survives flush so it spans jumps.
    always_ff @(posedge clock) begin
        if (!reset)
            stall_count <= 16'h0000;
        else if (mem_rd && !mem_ready && stall_count != 16'hFFFF)
            stall_count <= stall_count + 16'h0001;
    end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch; the bench models program_counter and byte memory.
module tb_instruction_fetch;

    logic        clock;
    logic        reset;
    logic [15:0] pc_count;
    logic        pc_increment;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic        mem_ready;
    logic        flush;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  instr_opcode;
    logic [15:0] instr_operand;
    logic [15:0] instr_pc;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_count;
`endif

    logic [7:0]  mem [0:65535];
    logic        pc_load;
    logic [15:0] pc_target;

    typedef struct {
        logic [7:0]  op;
        logic [15:0] opd;
        logic [15:0] pc;
    } exp_t;
    exp_t sb[$];

    int vectors = 0;
    int errors  = 0;

    instruction_fetch #(.LONG_BIT(7)) dut (
        .clock(clock),
`ifdef FETCH_STALL_CNT_EN
        .stall_count(stall_count),
`endif
        .reset(reset),
        .pc_count(pc_count),
        .pc_increment(pc_increment),
        .mem_addr(mem_addr),
        .mem_rd(mem_rd),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .flush(flush),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr_opcode(instr_opcode),
        .instr_operand(instr_operand),
        .instr_pc(instr_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign mem_rdata = mem[mem_addr];

    // Stand-in for program_counter: load has priority, otherwise increment on request.
    always @(posedge clock) begin
        if (pc_load)           pc_count <= pc_target;
        else if (pc_increment) pc_count <= pc_count + 16'h0001;
    end

    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_pc(input logic [15:0] a);
        pc_target = a;
        pc_load   = 1'b1;
        cyc();
        pc_load   = 1'b0;
    endtask

    task automatic check_hold(input string tag);
        exp_t e;
        int   n = 0;
        while (!instr_valid && n < 10) begin
            cyc();
            n++;
        end
        chk({tag, " valid"}, instr_valid, 1);
        chk({tag, " sb"}, sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, " opcode"}, instr_opcode, e.op);
            chk({tag, " operand"}, instr_operand, e.opd);
            chk({tag, " pc"}, instr_pc, e.pc);
        end
    endtask

    task automatic accept();
        instr_ready = 1'b1;
        cyc();
        instr_ready = 1'b0;
        chk("accept valid drop", instr_valid, 0);
    endtask

    initial begin
        reset       = 1'b0;
        flush       = 1'b0;
        instr_ready = 1'b0;
        mem_ready   = 1'b1;
        pc_load     = 1'b1;
        pc_target   = 16'h0000;
        mem[16'h0000] = 8'h12;

        // Reset with live memory: nothing may be requested or consumed.
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rst mem_rd", mem_rd, 0);
            chk("rst pc_increment", pc_increment, 0);
            chk("rst valid", instr_valid, 0);
        end
        chk("rst opcode", instr_opcode, 0);
        chk("rst operand", instr_operand, 0);
        chk("rst instr_pc", instr_pc, 0);
        pc_load = 1'b0;
        reset   = 1'b1;
        #1;
        chk("post-rst mem_rd", mem_rd, 1);
        chk("post-rst mem_addr", mem_addr, 16'h0000);
        sb.push_back('{8'h12, 16'h0000, 16'h0000});
        cyc();
        check_hold("first");

        // One-byte instruction, exact latency.
        mem[16'h0010] = 8'h05;
        set_pc(16'h0010);
        sb.push_back('{8'h05, 16'h0000, 16'h0010});
        accept();
        chk("short pc_increment", pc_increment, 1);
        chk("short mem_addr", mem_addr, 16'h0010);
        cyc();
        chk("short latency", instr_valid, 1);
        chk("short pc after", pc_count, 16'h0011);
        chk("short no inc in hold", pc_increment, 0);
        check_hold("short");

        // Three-byte instruction: one increment per byte, valid on cycle 3.
        mem[16'h0100] = 8'h80; mem[16'h0101] = 8'h34; mem[16'h0102] = 8'h12;
        set_pc(16'h0100);
        sb.push_back('{8'h80, 16'h1234, 16'h0100});
        accept();
        for (int i = 0; i < 3; i++) begin
            chk("long pc_increment", pc_increment, 1);
            chk("long mem_addr", mem_addr, 16'h0100 + 16'(i));
            chk("long valid low", instr_valid, 0);
            cyc();
        end
        chk("long pc after", pc_count, 16'h0103);
        check_hold("long");

        // Wait states on an opcode read.
        mem[16'h0200] = 8'h07;
        set_pc(16'h0200);
        sb.push_back('{8'h07, 16'h0000, 16'h0200});
        mem_ready = 1'b0;
        accept();
        for (int i = 0; i < 4; i++) begin
            chk("stall mem_rd", mem_rd, 1);
            chk("stall pc_increment", pc_increment, 0);
            chk("stall mem_addr", mem_addr, 16'h0200);
            cyc();
        end
`ifdef FETCH_STALL_CNT_EN
        chk("stall_count", stall_count, 4);
`endif
        mem_ready = 1'b1;
        #1;
        chk("stall release inc", pc_increment, 1);
        cyc();
        check_hold("stall");

        // Decoder back-pressure: outputs frozen, no prefetch.
        for (int i = 0; i < 5; i++) begin
            chk("hold valid", instr_valid, 1);
            chk("hold opcode", instr_opcode, 8'h07);
            chk("hold instr_pc", instr_pc, 16'h0200);
            chk("hold mem_rd", mem_rd, 0);
            chk("hold pc_increment", pc_increment, 0);
            cyc();
        end

        // flush together with instr_ready: flush wins, instruction killed.
        mem[16'h0300] = 8'h80; mem[16'h0301] = 8'h34; mem[16'h0302] = 8'h56;
        pc_target = 16'h0300; pc_load = 1'b1; flush = 1'b1; instr_ready = 1'b1;
        #1;
        chk("flush+rdy mem_rd", mem_rd, 0);
        chk("flush+rdy pc_increment", pc_increment, 0);
        cyc();
        flush = 1'b0; instr_ready = 1'b0; pc_load = 1'b0;
        #1;
        chk("flush+rdy valid", instr_valid, 0);
        chk("flush+rdy mem_rd", mem_rd, 1);
        chk("flush+rdy mem_addr", mem_addr, 16'h0300);

        // Flush in F_HI after two bytes consumed.
        cyc();
        cyc();
        chk("F_HI mem_addr", mem_addr, 16'h0302);
        chk("F_HI outputs held", instr_opcode, 8'h07);
        mem[16'h2000] = 8'h01;
        pc_target = 16'h2000; pc_load = 1'b1; flush = 1'b1;
        #1;
        chk("flush mem_rd", mem_rd, 0);
        chk("flush pc_increment", pc_increment, 0);
        cyc();
        flush = 1'b0; pc_load = 1'b0;
        #1;
        chk("post-flush valid", instr_valid, 0);
        chk("post-flush mem_addr", mem_addr, 16'h2000);
        chk("post-flush mem_rd", mem_rd, 1);
        chk("post-flush opcode held", instr_opcode, 8'h07);
        chk("post-flush operand held", instr_operand, 16'h0000);
        sb.push_back('{8'h01, 16'h0000, 16'h2000});
        cyc();
        check_hold("after flush");

        // Long instruction straddling the PC wrap.
        mem[16'hFFFF] = 8'h81; mem[16'h0000] = 8'hCD; mem[16'h0001] = 8'hAB;
        set_pc(16'hFFFF);
        sb.push_back('{8'h81, 16'hABCD, 16'hFFFF});
        accept();
        cyc();
        chk("wrap mid-fetch opcode held", instr_opcode, 8'h01);
        chk("wrap mid-fetch addr", mem_addr, 16'h0000);
        check_hold("wrap");
        chk("wrap pc after", pc_count, 16'h0002);
        accept();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
